// File: rtl/seq_detect_param.sv
// Parametrised serial bit-sequence detector with a runtime-loadable pattern,
// overlap/non-overlap mode, a registered match pulse and a saturating match counter.
module seq_detect_param #(
    parameter int unsigned        SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b0110,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic               overlap_en,
    input  logic               pattern_load,
    input  logic [SEQ_LEN-1:0] pattern_in,
    input  logic               clear_count,
    output logic               out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam int unsigned       FILL_W   = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);

    logic [SEQ_LEN-1:0] pattern_q;
    logic [SEQ_LEN-1:0] hist;
    logic [SEQ_LEN-1:0] hist_next;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_next;
    logic [CNT_W-1:0]   cnt_inc;
    logic               match;

    always_comb begin
        hist_next = {hist[SEQ_LEN-2:0], in};
        fill_next = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
        cnt_inc   = match_count + CNT_W'(1);
        // A load in the same cycle discards the incoming bit, so it can never match.
        match     = in_valid && !pattern_load &&
                    (fill_next == FILL_MAX) && (hist_next == pattern_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q   <= PATTERN;
            hist        <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            out <= match;

            if (pattern_load) begin
                pattern_q <= pattern_in;
                hist      <= '0;
                fill      <= '0;
            end else if (in_valid) begin
                hist <= hist_next;
                fill <= (match && !overlap_en) ? '0 : fill_next;
            end

            if (clear_count) begin
                match_count <= '0;
                count_sat   <= 1'b0;
            end else if (match && (match_count != '1)) begin
                match_count <= cnt_inc;
                if (cnt_inc == '1) begin
                    count_sat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a queue-based reference model checked every
// cycle on two instances (8-bit and 2-bit counters), plus literal per-bit expectations.
module tb_seq_detect_param;

    localparam int SEQ_LEN = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         din = 1'b0;
    logic         in_valid = 1'b0;
    logic         overlap_en = 1'b1;
    logic         pattern_load = 1'b0;
    logic [3:0]   pattern_in = '0;
    logic         clear_count = 1'b0;

    logic         out8, out2;
    logic [7:0]   cnt8;
    logic [1:0]   cnt2;
    logic         sat8, sat2;

    int checks = 0;
    int errors = 0;

    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b0110), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid),
        .overlap_en(overlap_en), .pattern_load(pattern_load), .pattern_in(pattern_in),
        .clear_count(clear_count), .out(out8), .match_count(cnt8), .count_sat(sat8)
    );

    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b0110), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid),
        .overlap_en(overlap_en), .pattern_load(pattern_load), .pattern_in(pattern_in),
        .clear_count(clear_count), .out(out2), .match_count(cnt2), .count_sat(sat2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: keeps the qualifying bits since the last clear point.
    bit         q[$];
    logic [3:0] m_pat;
    bit         m_out = 1'b0;
    int         m_c8 = 0, m_c2 = 0;
    bit         m_s8 = 1'b0, m_s2 = 1'b0;
    bit         m_live = 1'b0;

    always @(posedge clk) begin
        bit         hit;
        logic [3:0] w;
        hit = 1'b0;
        if (reset) begin
            q.delete();
            m_pat  = 4'b0110;
            m_c8   = 0;
            m_c2   = 0;
            m_s8   = 1'b0;
            m_s2   = 1'b0;
            m_live = 1'b1;
        end else begin
            if (pattern_load) begin
                m_pat = pattern_in;
                q.delete();
            end else if (in_valid) begin
                q.push_back(din);
                if (q.size() > SEQ_LEN) void'(q.pop_front());
                if (q.size() == SEQ_LEN) begin
                    w = '0;
                    foreach (q[i]) w = {w[2:0], q[i]};
                    hit = (w == m_pat);
                    if (hit && !overlap_en) q.delete();
                end
            end
            if (clear_count) begin
                m_c8 = 0; m_c2 = 0; m_s8 = 1'b0; m_s2 = 1'b0;
            end else if (hit) begin
                if (m_c8 < 255) m_c8++;
                if (m_c8 == 255) m_s8 = 1'b1;
                if (m_c2 < 3) m_c2++;
                if (m_c2 == 3) m_s2 = 1'b1;
            end
        end
        m_out = hit;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_out8", out8, m_out);
            chk("model_out2", out2, m_out);
            chk("model_cnt8", cnt8, m_c8);
            chk("model_cnt2", cnt2, m_c2);
            chk("model_sat8", sat8, m_s8);
            chk("model_sat2", sat2, m_s2);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_out", out8, 0);
        chk("rst_cnt8", cnt8, 0);
        chk("rst_sat8", sat8, 0);
        chk("rst_cnt2", cnt2, 0);
    endtask

    // '0'/'1' = accepted bit, '-' = in_valid low (in held at 1); e gives out after each edge.
    task automatic run(input string s, input string e);
        for (int i = 0; i < s.len(); i++) begin
            in_valid = (s[i] != "-");
            din      = (s[i] == "1") || (s[i] == "-");
            @(posedge clk); #1;
            chk($sformatf("out8_bit%0d", i), out8, e[i] == "1");
            chk($sformatf("out2_bit%0d", i), out2, e[i] == "1");
        end
        in_valid = 1'b0;
        din      = 1'b0;
    endtask

    task automatic chk_cnt(input int e8, input int e2, input int es2);
        chk("lit_cnt8", cnt8, e8);
        chk("lit_cnt2", cnt2, e2);
        chk("lit_sat2", sat2, es2);
        chk("lit_sat8", sat8, 0);
    endtask

    initial begin
        // Overlapping detection of 0110 in 0110110
        overlap_en = 1'b1;
        do_reset();
        run("0110110", "0001001");
        chk_cnt(2, 2, 0);

        // Non-overlapping on the same stream
        do_reset();
        overlap_en = 1'b0;
        run("0110110", "0001000");
        chk_cnt(1, 1, 0);

        // in_valid gap mid-pattern
        do_reset();
        overlap_en = 1'b1;
        run("01---10", "0000001");
        chk_cnt(1, 1, 0);

        // Load 1011 over a partial match; incoming bit during load is discarded
        do_reset();
        overlap_en = 1'b0;
        run("011", "000");
        pattern_load = 1'b1;
        pattern_in   = 4'b1011;
        run("0", "0");
        pattern_load = 1'b0;
        run("1011", "0001");
        run("0110", "0000");
        chk_cnt(1, 1, 0);

        // Counter saturation on the 2-bit instance, then clear_count with a match
        do_reset();
        overlap_en = 1'b1;
        run("0110110", "0001001");
        chk_cnt(2, 2, 0);
        run("110", "001");
        chk_cnt(3, 3, 1);
        run("110", "001");
        chk_cnt(4, 3, 1);
        run("11", "00");
        clear_count = 1'b1;
        run("0", "1");
        clear_count = 1'b0;
        chk_cnt(0, 0, 0);

        // Reset mid-stream reverts the pattern to 0110
        do_reset();
        pattern_load = 1'b1;
        pattern_in   = 4'b1011;
        run("0", "0");
        pattern_load = 1'b0;
        run("011", "000");
        reset    = 1'b1;
        in_valid = 1'b1;
        din      = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        run("0", "0");
        chk_cnt(0, 0, 0);
        run("0110", "0001");
        chk_cnt(1, 1, 0);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
